// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants and encodings for the UART word-sender path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int         DBITS        = 8;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Which byte of the frame is currently presented to the Transmitter.
    typedef enum logic [1:0] {
        SEL_HDR  = 2'd0,
        SEL_DATA = 2'd1,
        SEL_CSUM = 2'd2
    } sel_t;

endpackage

`default_nettype wire

// File: rtl/sync_word_fifo.sv
// ============================================================================
// Module  : sync_word_fifo
// Brief   : Single-clock word FIFO, 2**ADDR_W entries, asynchronous-read data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_word_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;

    assign full    = (r_count == (ADDR_W+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_word_sender.sv
// ============================================================================
// Module  : uart_word_sender
// Brief   : Frames buffered words as SYNC, data bytes MSB first, XOR checksum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_word_sender
    import uart_pkg::*;
#(
    parameter int         WORD_W    = 32,
    parameter int         FIFO_EXP  = 2,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_busy,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_done
);

    localparam int NBYTES = WORD_W / DBITS;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_rd;
    logic [WORD_W-1:0] w_fifo_dout;
    logic [DBITS-1:0]  w_next_byte;

    state_t            r_state;
    sel_t              r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [DBITS-1:0]  r_csum;
    logic [WORD_W-1:0] r_shift;
    logic              r_tx_start;
    logic [DBITS-1:0]  r_tx_data;
    logic              r_overflow;

    sync_word_fifo #(
        .WIDTH  (WORD_W),
        .ADDR_W (FIFO_EXP)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (i_wr_en),
        .wr_data (i_wr_data),
        .rd_en   (w_fifo_rd),
        .rd_data (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign w_fifo_rd   = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_next_byte = r_shift[WORD_W-1 -: DBITS];

    assign o_full      = w_fifo_full;
    assign o_overflow  = r_overflow;
    assign o_busy      = (r_state != ST_IDLE) || !w_fifo_empty;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;

    // Start pulse and byte are registered on entry to SEND so they line up
    // with the SEND state; WAIT simply leaves r_tx_data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_HDR;
            r_cnt      <= '0;
            r_csum     <= '0;
            r_shift    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (i_wr_en && w_fifo_full) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_shift    <= w_fifo_dout;
                        r_csum     <= '0;
                        r_cnt      <= '0;
                        r_sel      <= SEL_HDR;
                        r_tx_data  <= SYNC_BYTE;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_tx_done) begin
                        case (r_sel)
                            SEL_HDR: begin
                                r_sel      <= SEL_DATA;
                                r_cnt      <= '0;
                                r_tx_data  <= w_next_byte;
                                r_csum     <= r_csum ^ w_next_byte;
                                r_shift    <= r_shift << DBITS;
                                r_tx_start <= 1'b1;
                                r_state    <= ST_SEND;
                            end
                            SEL_DATA: begin
                                if (r_cnt == LAST_BYTE) begin
                                    r_sel     <= SEL_CSUM;
                                    r_tx_data <= r_csum;
                                end else begin
                                    r_cnt     <= r_cnt + 1'b1;
                                    r_tx_data <= w_next_byte;
                                    r_csum    <= r_csum ^ w_next_byte;
                                    r_shift   <= r_shift << DBITS;
                                end
                                r_tx_start <= 1'b1;
                                r_state    <= ST_SEND;
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
